// File: rtl/frame_stream_sequencer.sv
// -----------------------------------------------------------------------------
// frame_stream_sequencer
//
// Reads a WIDTH x HEIGHT RGB444 frame buffer in raster order and streams it
// out as one Avalon-ST packet per frame (SOP on the first pixel, EOP on the
// last). Each read carries sop/eop/valid tags through an RD_LAT-deep shift
// register that runs beside the RAM. The returning word and its tags are
// pushed into a small FIFO. Reads are only issued while there is a free FIFO
// slot for every read in flight, so backpressure can never overflow the FIFO.
// One of two frame bases is chosen at each frame start, which gives double
// buffering.
//
// Ports:
//   clk         single clock
//   reset_n     asynchronous active-low reset
//   enable      run frames back-to-back while high
//   buf_sel     frame buffer select, sampled only at frame start
//   rdaddress   frame-buffer read address
//   rden        read issued this cycle
//   rddata      RAM output, valid RD_LAT cycles after rden
//   src_data    {R,R,00, G,G,00, B,B,00} 30-bit pixel
//   src_valid   beat available
//   src_ready   sink accepts beat
//   src_sop     first pixel of frame
//   src_eop     last pixel of frame
//   busy        sequencer is not idle
//   frame_done  high in the cycle whose closing edge accepts the EOP beat
// -----------------------------------------------------------------------------
module frame_stream_sequencer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 18,
    parameter int BUF1_BASE  = 76800,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              buf_sel,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [11:0]       rddata,
    output logic [29:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic              busy,
    output logic              frame_done
);

    localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [X_W-1:0]    x_reg, x_next;
    logic [Y_W-1:0]    y_reg, y_next;

    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_sop_reg;
    logic [RD_LAT-1:0] tag_eop_reg;

    logic [CNT_W-1:0]  inflight_reg;
    logic [CNT_W-1:0]  fifo_count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    logic [11:0]       fifo_data_mem [FIFO_DEPTH];
    logic              fifo_sop_mem  [FIFO_DEPTH];
    logic              fifo_eop_mem  [FIFO_DEPTH];

    logic              credit_ok;
    logic              issue_sop;
    logic              issue_eop;
    logic              ret;
    logic              push;
    logic              pop;
    logic              eop_accept;
    logic [11:0]       head_pixel;
    logic [ADDR_W-1:0] sel_base;

    // Every read in flight already owns a FIFO slot, so a push always has room.
    assign credit_ok = (32'(inflight_reg) + 32'(fifo_count_reg)) < FIFO_DEPTH;
    assign issue_sop = (x_reg == '0) && (y_reg == '0);
    assign issue_eop = (x_reg == X_W'(WIDTH - 1)) && (y_reg == Y_W'(HEIGHT - 1));
    assign sel_base  = buf_sel ? ADDR_W'(BUF1_BASE) : '0;

    assign ret        = tag_valid_reg[RD_LAT-1];
    assign push       = ret;
    assign src_valid  = (fifo_count_reg != '0);
    assign pop        = src_valid & src_ready;
    assign eop_accept = pop & src_eop;
    assign frame_done = eop_accept;
    assign busy       = (state_reg != S_IDLE);
    assign rdaddress  = addr_reg;

    // Storage contents are not cleared by reset, so the outputs are gated
    // with src_valid to present zeros whenever the FIFO is empty.
    assign head_pixel = fifo_data_mem[rd_ptr_reg];
    assign src_data   = src_valid ? {head_pixel[11:8], head_pixel[11:8], 2'b00,
                                     head_pixel[7:4],  head_pixel[7:4],  2'b00,
                                     head_pixel[3:0],  head_pixel[3:0],  2'b00} : '0;
    assign src_sop    = src_valid & fifo_sop_mem[rd_ptr_reg];
    assign src_eop    = src_valid & fifo_eop_mem[rd_ptr_reg];

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        rden       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    addr_next  = sel_base;
                    x_next     = '0;
                    y_next     = '0;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                rden = credit_ok;
                if (credit_ok) begin
                    addr_next = addr_reg + ADDR_W'(1);
                    if (x_reg == X_W'(WIDTH - 1)) begin
                        x_next = '0;
                        y_next = y_reg + Y_W'(1);
                    end else begin
                        x_next = x_reg + X_W'(1);
                    end
                    if (issue_eop) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (eop_accept) begin
                    if (enable) begin
                        addr_next  = sel_base;
                        x_next     = '0;
                        y_next     = '0;
                        state_next = S_RUN;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------- tags beside RAM latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_reg <= '0;
            tag_sop_reg   <= '0;
            tag_eop_reg   <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_sop_reg[i]   <= tag_sop_reg[i-1];
                tag_eop_reg[i]   <= tag_eop_reg[i-1];
            end
            tag_valid_reg[0] <= rden;
            tag_sop_reg[0]   <= rden & issue_sop;
            tag_eop_reg[0]   <= rden & issue_eop;
        end
    end

    // ------------------------------------------------- credits and FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_reg   <= '0;
            fifo_count_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            inflight_reg   <= inflight_reg + CNT_W'(rden) - CNT_W'(ret);
            fifo_count_reg <= fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_mem[wr_ptr_reg] <= rddata;
            fifo_sop_mem[wr_ptr_reg]  <= tag_sop_reg[RD_LAT-1];
            fifo_eop_mem[wr_ptr_reg]  <= tag_eop_reg[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_stream_sequencer
//
// Two instances share one clock:
//   dut_a : default 320x240 geometry, RD_LAT=1 (full frame, stall, reset)
//   dut_b : 4x3 geometry, RD_LAT=2, BUF1_BASE=16 (backpressure, enable drop,
//           buffer switch)
// Both RAM models return mem[a] = a[11:0].
// -----------------------------------------------------------------------------
module tb_frame_stream_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // ---------------------------------------------------------------- dut_a
    logic        reset_n_a, enable_a, buf_sel_a, rden_a, src_ready_a;
    logic        src_valid_a, src_sop_a, src_eop_a, busy_a, frame_done_a;
    logic [17:0] rdaddress_a;
    logic [11:0] rddata_a = '0;
    logic [29:0] src_data_a;

    frame_stream_sequencer dut_a (
        .clk        (clk),
        .reset_n    (reset_n_a),
        .enable     (enable_a),
        .buf_sel    (buf_sel_a),
        .rdaddress  (rdaddress_a),
        .rden       (rden_a),
        .rddata     (rddata_a),
        .src_data   (src_data_a),
        .src_valid  (src_valid_a),
        .src_ready  (src_ready_a),
        .src_sop    (src_sop_a),
        .src_eop    (src_eop_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    always @(posedge clk) if (rden_a) rddata_a <= rdaddress_a[11:0];

    // ---------------------------------------------------------------- dut_b
    logic        reset_n_b, enable_b, buf_sel_b, rden_b, src_ready_b;
    logic        src_valid_b, src_sop_b, src_eop_b, busy_b, frame_done_b;
    logic [17:0] rdaddress_b;
    logic [11:0] q1_b = '0;
    logic [11:0] q2_b = '0;
    logic [29:0] src_data_b;

    frame_stream_sequencer #(
        .WIDTH(4), .HEIGHT(3), .ADDR_W(18), .BUF1_BASE(16), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n_b),
        .enable     (enable_b),
        .buf_sel    (buf_sel_b),
        .rdaddress  (rdaddress_b),
        .rden       (rden_b),
        .rddata     (q2_b),
        .src_data   (src_data_b),
        .src_valid  (src_valid_b),
        .src_ready  (src_ready_b),
        .src_sop    (src_sop_b),
        .src_eop    (src_eop_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    always @(posedge clk) begin
        if (rden_b) q1_b <= rdaddress_b[11:0];
        q2_b <= q1_b;
    end

    // -------------------------------------------------------------- helpers
    function automatic logic [31:0] expand(input int a);
        logic [11:0] p;
        p = a[11:0];
        return {2'b00, p[11:8], p[11:8], 2'b00, p[7:4], p[7:4], 2'b00, p[3:0], p[3:0], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int beats, reads, issued, sops, eops, dones, eop_k;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n_a = 1'b0; enable_a = 1'b0; buf_sel_a = 1'b0; src_ready_a = 1'b0;
        reset_n_b = 1'b0; enable_b = 1'b0; buf_sel_b = 1'b0; src_ready_b = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state
        chk("rst_rdaddress", 32'(rdaddress_a), 32'd0);
        chk("rst_rden",      32'(rden_a),      32'd0);
        chk("rst_valid",     32'(src_valid_a), 32'd0);
        chk("rst_data",      32'(src_data_a),  32'd0);
        chk("rst_busy",      32'(busy_a),      32'd0);
        chk("rst_b_busy",    32'(busy_b),      32'd0);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;
        @(negedge clk);
        chk("idle_rden", 32'(rden_a), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // ---- full 320x240 frame, sink always ready, enable pulsed
        src_ready_a = 1'b1;
        enable_a    = 1'b1;
        @(negedge clk);
        enable_a = 1'b0;
        beats = 0;
        for (int k = 0; k < 80000 && beats < 76800; k++) begin
            if (src_valid_a) begin
                if (beats == 0) chk("ff_first_cycle", 32'(k), 32'd2);
                chk("ff_data", 32'(src_data_a), expand(beats));
                chk("ff_sop",  32'(src_sop_a),  32'(beats == 0));
                chk("ff_eop",  32'(src_eop_a),  32'(beats == 76799));
                chk("ff_done", 32'(frame_done_a), 32'(beats == 76799));
                beats++;
            end else if (beats > 0) begin
                chk("ff_no_gap", 32'(src_valid_a), 32'd1);
            end
            @(negedge clk);
        end
        chk("ff_beats",      32'(beats),  32'd76800);
        chk("ff_busy_after", 32'(busy_a), 32'd0);
        chk("ff_rden_after", 32'(rden_a), 32'd0);
        $display("full frame: %0d beats", beats);

        // ---- held beat under backpressure
        src_ready_a = 1'b0;
        enable_a    = 1'b1;
        @(negedge clk);
        enable_a = 1'b0;
        reads = 0;
        for (int k = 0; k < 20 && !src_valid_a; k++) begin
            reads += 32'(rden_a);
            @(negedge clk);
        end
        chk("st_valid", 32'(src_valid_a), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("st_data", 32'(src_data_a), expand(0));
            chk("st_sop",  32'(src_sop_a),  32'd1);
            chk("st_eop",  32'(src_eop_a),  32'd0);
            reads += 32'(rden_a);
            @(negedge clk);
        end
        chk("st_reads",    32'(reads),  32'd4);
        chk("st_rden_off", 32'(rden_a), 32'd0);
        $display("stall: %0d reads outstanding", reads);

        // ---- asynchronous reset mid-frame
        src_ready_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_busy_before", 32'(busy_a), 32'd1);
        #2 reset_n_a = 1'b0;
        #1;
        chk("mr_rdaddress", 32'(rdaddress_a),  32'd0);
        chk("mr_rden",      32'(rden_a),       32'd0);
        chk("mr_valid",     32'(src_valid_a),  32'd0);
        chk("mr_sop",       32'(src_sop_a),    32'd0);
        chk("mr_eop",       32'(src_eop_a),    32'd0);
        chk("mr_data",      32'(src_data_a),   32'd0);
        chk("mr_busy",      32'(busy_a),       32'd0);
        chk("mr_done",      32'(frame_done_a), 32'd0);
        enable_a = 1'b1;
        @(negedge clk);
        reset_n_a = 1'b1;
        @(negedge clk);
        chk("mr_restart_rden", 32'(rden_a),      32'd1);
        chk("mr_restart_addr", 32'(rdaddress_a), 32'd0);
        $display("reset mid-frame: restart addr %0d", rdaddress_a);
        reset_n_a = 1'b0;
        enable_a  = 1'b0;

        // ---- 4x3 frame, RD_LAT=2, random backpressure, enable dropped at beat 5
        enable_b = 1'b1;
        buf_sel_b = 1'b0;
        beats = 0; sops = 0; eops = 0; dones = 0; issued = 0;
        for (int k = 0; k < 400 && beats < 12; k++) begin
            @(negedge clk);
            src_ready_b = 1'($urandom_range(0, 1));
            #1;
            chk("bp_occupancy", 32'((issued - beats) <= 4), 32'd1);
            if (frame_done_b) dones++;
            if (src_valid_b && src_ready_b) begin
                chk("bp_data", 32'(src_data_b), expand(beats));
                chk("bp_sop",  32'(src_sop_b),  32'(beats == 0));
                chk("bp_eop",  32'(src_eop_b),  32'(beats == 11));
                sops += 32'(src_sop_b);
                eops += 32'(src_eop_b);
                beats++;
                if (beats == 5) enable_b = 1'b0;
            end
            issued += 32'(rden_b);
        end
        chk("bp_beats", 32'(beats), 32'd12);
        chk("bp_sops",  32'(sops),  32'd1);
        chk("bp_eops",  32'(eops),  32'd1);
        chk("bp_done",  32'(dones), 32'd1);
        chk("bp_issued", 32'(issued), 32'd12);
        src_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_idle_busy", 32'(busy_b), 32'd0);
            chk("bp_idle_rden", 32'(rden_b), 32'd0);
        end
        $display("backpressure frame: %0d beats, %0d done pulses", beats, dones);

        // ---- buffer switch between frames, enable held across frame 0
        src_ready_b = 1'b1;
        buf_sel_b   = 1'b0;
        enable_b    = 1'b1;
        beats = 0; reads = 0; eop_k = 0;
        for (int k = 0; k < 200 && beats < 24; k++) begin
            @(negedge clk);
            if (rden_b) begin
                chk("bs_addr", 32'(rdaddress_b), 32'((reads < 12) ? reads : reads + 4));
                reads++;
                if (reads == 6)  buf_sel_b = 1'b1;
                if (reads == 13) enable_b  = 1'b0;
            end
            if (src_valid_b) begin
                chk("bs_data", 32'(src_data_b), expand((beats < 12) ? beats : beats + 4));
                chk("bs_sop",  32'(src_sop_b),  32'(beats == 0 || beats == 12));
                chk("bs_eop",  32'(src_eop_b),  32'(beats == 11 || beats == 23));
                if (beats == 11) eop_k = k;
                if (beats == 12) chk("bs_gap", 32'((k - eop_k - 1) <= 4), 32'd1);
                beats++;
            end
        end
        chk("bs_beats", 32'(beats), 32'd24);
        chk("bs_reads", 32'(reads), 32'd24);
        repeat (3) @(negedge clk);
        chk("bs_idle_busy", 32'(busy_b), 32'd0);
        $display("buffer switch: %0d reads, %0d beats", reads, beats);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
